// File: rtl/program_select_ctl.sv
// Front-panel command selector: synchronises and debounces the command buttons,
// then issues one program_selector value per press and holds it until the processor acks.
module program_select_ctl #(
  parameter int NBTN        = 4,
  parameter int DB_CYCLES   = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int SEL_WIDTH   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NBTN-1:0]      btn,
  input  logic                 busy,
  input  logic                 ack,
  output logic [SEL_WIDTH-1:0] program_selector,
  output logic                 start,
  output logic                 pending,
  output logic [NBTN-1:0]      btn_clean
);

  localparam int IW = (NBTN > 1) ? $clog2(NBTN) : 1;
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_WAIT_ACK,
    ST_RELEASE
  } state_t;

  state_t          state, state_n;
  logic [NBTN-1:0] sync1, sync2, clean_d, rise;
  logic [CW-1:0]   cnt [NBTN];
  logic [IW-1:0]   qidx, qidx_n, win;
  logic [HW-1:0]   hcnt, hcnt_n;
  logic [SEL_WIDTH-1:0] sel_n;
  logic            start_n, pend_n, any_rise;

  // Synchroniser, per-button debounce and edge-detect history
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      btn_clean <= '0;
      clean_d   <= '0;
      for (int unsigned i = 0; i < NBTN; i++) cnt[i] <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      clean_d <= btn_clean;
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (sync2[i] == btn_clean[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_MAX) begin
          btn_clean[i] <= sync2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise     = btn_clean & ~clean_d;
  assign any_rise = |rise;

  // Lowest-index rising edge wins
  always_comb begin
    logic found;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NBTN; i++) begin
      if (rise[i] && !found) begin
        win   = IW'(i);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= ST_IDLE;
      program_selector <= '0;
      start            <= 1'b0;
      pending          <= 1'b0;
      qidx             <= '0;
      hcnt             <= '0;
    end else begin
      state            <= state_n;
      program_selector <= sel_n;
      start            <= start_n;
      pending          <= pend_n;
      qidx             <= qidx_n;
      hcnt             <= hcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    sel_n   = program_selector;
    start_n = 1'b0;
    pend_n  = pending;
    qidx_n  = qidx;
    hcnt_n  = hcnt;
    unique case (state)
      ST_IDLE: begin
        // A queued command takes precedence over any fresh edge in the same cycle
        if (pending && !busy) begin
          sel_n   = SEL_WIDTH'(qidx) + SEL_WIDTH'(1);
          start_n = 1'b1;
          pend_n  = 1'b0;
          hcnt_n  = '0;
          state_n = ST_HOLD;
        end else if (any_rise && !busy) begin
          sel_n   = SEL_WIDTH'(win) + SEL_WIDTH'(1);
          start_n = 1'b1;
          hcnt_n  = '0;
          state_n = ST_HOLD;
        end else if (any_rise && busy && !pending) begin
          qidx_n = win;
          pend_n = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hcnt == HOLD_MAX) state_n = ST_WAIT_ACK;
        else                  hcnt_n  = hcnt + HW'(1);
      end
      ST_WAIT_ACK: begin
        if (ack) begin
          sel_n   = '0;
          state_n = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!(|btn_clean)) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_program_select_ctl.sv
// Bench for program_select_ctl: scoreboard of expected selector values checked on
// every start pulse, plus directed timing/state checks.
module tb_program_select_ctl;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  btn;
  logic        busy;
  logic        ack;
  logic [31:0] program_selector;
  logic        start;
  logic        pending;
  logic [3:0]  btn_clean;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] exp_q[$];
  logic        prev_start = 1'b0;

  program_select_ctl #(
    .NBTN(4), .DB_CYCLES(4), .HOLD_CYCLES(2), .SEL_WIDTH(32)
  ) dut (
    .clock(clock), .reset(reset), .btn(btn), .busy(busy), .ack(ack),
    .program_selector(program_selector), .start(start), .pending(pending),
    .btn_clean(btn_clean)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Scoreboard consumer: every start pulse must match the next expected selector
  always @(negedge clock) begin
    if (!reset && start) begin
      check_val("start_width", {31'b0, prev_start}, 32'd0);
      if (exp_q.size() == 0) check_val("unexpected_start", program_selector, 32'd0);
      else                   check_val("sb_selector", program_selector, exp_q.pop_front());
    end
    prev_start <= start;
  end

  task automatic do_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; btn = '0; busy = 1'b0; ack = 1'b0;
    tick(3);
    check_val("rst_sel", program_selector, 32'd0);
    check_val("rst_start", {31'b0, start}, 32'd0);
    check_val("rst_pending", {31'b0, pending}, 32'd0);
    check_val("rst_clean", {28'b0, btn_clean}, 32'd0);
    reset = 1'b0;
    tick(2);

    // 1: latency and ack handling
    btn[0] = 1'b1;
    exp_q.push_back(32'd1);
    tick(6);
    check_val("t1_sel_c6", program_selector, 32'd0);
    check_val("t1_clean_c6", {28'b0, btn_clean}, 32'd1);
    tick(1);
    check_val("t1_sel_c7", program_selector, 32'd1);
    check_val("t1_start_c7", {31'b0, start}, 32'd1);
    ack = 1'b1;
    tick(1);
    check_val("t1_start_c8", {31'b0, start}, 32'd0);
    tick(1);
    check_val("t1_sel_c9", program_selector, 32'd1);
    tick(1);
    ack = 1'b0;
    check_val("t1_sel_c10", program_selector, 32'd0);
    btn[0] = 1'b0;
    tick(12);

    // 2: short glitch filtered
    btn[2] = 1'b1;
    tick(3);
    btn[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check_val("t2_clean", {28'b0, btn_clean}, 32'd0);
      check_val("t2_sel", program_selector, 32'd0);
      tick(1);
    end

    // 3: simultaneous rises, lowest index wins
    btn[1] = 1'b1; btn[3] = 1'b1;
    exp_q.push_back(32'd2);
    tick(7);
    check_val("t3_sel", program_selector, 32'd2);
    tick(2);
    do_ack();
    check_val("t3_sel_acked", program_selector, 32'd0);
    tick(3);
    btn = '0;
    tick(15);
    check_val("t3_sel_after", program_selector, 32'd0);

    // 4: command queued while busy; second press ignored
    busy = 1'b1;
    btn[3] = 1'b1;
    tick(7);
    check_val("t4_pending", {31'b0, pending}, 32'd1);
    check_val("t4_sel_busy", program_selector, 32'd0);
    btn[3] = 1'b0;
    tick(10);
    btn[1] = 1'b1;
    tick(10);
    check_val("t4_pending2", {31'b0, pending}, 32'd1);
    check_val("t4_sel_busy2", program_selector, 32'd0);
    btn[1] = 1'b0;
    tick(10);
    exp_q.push_back(32'd4);
    busy = 1'b0;
    tick(1);
    check_val("t4_sel", program_selector, 32'd4);
    check_val("t4_start", {31'b0, start}, 32'd1);
    check_val("t4_pending_clr", {31'b0, pending}, 32'd0);
    tick(2);
    do_ack();
    tick(15);
    check_val("t4_sel_after", program_selector, 32'd0);

    // 5: button held through ack does not re-trigger
    btn[0] = 1'b1;
    exp_q.push_back(32'd1);
    tick(9);
    do_ack();
    tick(20);
    check_val("t5_sel_held", program_selector, 32'd0);
    btn[0] = 1'b0;
    tick(10);
    btn[0] = 1'b1;
    exp_q.push_back(32'd1);
    tick(7);
    check_val("t5_sel_repress", program_selector, 32'd1);
    tick(2);
    do_ack();
    btn[0] = 1'b0;
    tick(12);

    // 6a: reset during WAIT_ACK
    btn[2] = 1'b1;
    exp_q.push_back(32'd3);
    tick(9);
    check_val("t6_sel_pre", program_selector, 32'd3);
    reset = 1'b1;
    btn[2] = 1'b0;
    tick(1);
    check_val("t6_sel_rst", program_selector, 32'd0);
    check_val("t6_start_rst", {31'b0, start}, 32'd0);
    reset = 1'b0;
    tick(15);
    check_val("t6_sel_post", program_selector, 32'd0);

    // 6b: reset discards a queued command
    busy = 1'b1;
    btn[0] = 1'b1;
    tick(7);
    check_val("t6b_pending_pre", {31'b0, pending}, 32'd1);
    reset = 1'b1;
    btn[0] = 1'b0;
    tick(1);
    check_val("t6b_pending_rst", {31'b0, pending}, 32'd0);
    check_val("t6b_sel_rst", program_selector, 32'd0);
    reset = 1'b0;
    busy = 1'b0;
    tick(15);
    check_val("t6b_sel_post", program_selector, 32'd0);
    check_val("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
